// File: rtl/canary_link_pkg.sv
// Shared definitions for the CPU-to-FPGA link: word tags, HDR field layout,
// transmitter FSM states and the held request record.
package canary_link_pkg;

  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_ADDR = 2'b10;
  localparam logic [1:0] TAG_DATA = 2'b11;

  localparam int HDR_WE_BIT   = 31;
  localparam int HDR_MASK_LSB = 27;
  localparam int HDR_SEQ_LSB  = 19;
  localparam int LINK_SEQ_W   = 8;

  typedef enum logic [1:0] {IDLE, S_HDR, S_ADDR, S_DATA} tx_state_t;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [3:0]            wmask;
    logic [LINK_SEQ_W-1:0] seq;
  } link_req_t;

  function automatic logic [31:0] hdr_payload(input link_req_t r);
    logic [31:0] p;
    p = '0;
    p[HDR_WE_BIT]                     = r.we;
    p[HDR_MASK_LSB +: 4]              = r.wmask;
    p[HDR_SEQ_LSB +: LINK_SEQ_W]      = r.seq;
    return p;
  endfunction

endpackage

// File: rtl/cpu_fifo_tx.sv
// Serializes CPU memory requests into tagged HDR/ADDR[/DATA] words for the
// CPU-to-FPGA async FIFO write port, stalling while the FIFO reports full.
module cpu_fifo_tx
  import canary_link_pkg::*;
#(
  parameter int WIDTH     = 34,
  parameter int SEQ_WIDTH = 8
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_wmask,
  output logic [WIDTH-1:0] fifo_data,
  output logic             fifo_w_en,
  input  logic             fifo_full,
  output logic             busy,
  output logic [15:0]      txn_count
);

  tx_state_t             state_q, state_d;
  link_req_t             hold_q, hold_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  last_word, accept;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    seq_d     = seq_q;
    cnt_d     = cnt_q;
    fifo_data = '0;

    last_word = (state_q == S_ADDR && !hold_q.we) || (state_q == S_DATA);
    fifo_w_en = (state_q != IDLE) && !fifo_full;
    req_ready = (state_q == IDLE) || (last_word && !fifo_full);
    accept    = req_valid && req_ready;

    case (state_q)
      S_HDR: begin
        fifo_data = {TAG_HDR, hdr_payload(hold_q)};
        if (fifo_w_en) state_d = S_ADDR;
      end
      S_ADDR: begin
        fifo_data = {TAG_ADDR, hold_q.addr};
        if (fifo_w_en && hold_q.we) state_d = S_DATA;
      end
      S_DATA: fifo_data = {TAG_DATA, hold_q.wdata};
      default: ;
    endcase

    if (fifo_w_en && last_word) begin
      cnt_d   = cnt_q + 16'd1;
      state_d = IDLE;
    end

    // An accept in the last-word cycle overrides the return to IDLE.
    if (accept) begin
      state_d      = S_HDR;
      hold_d.we    = req_we;
      hold_d.addr  = req_addr;
      hold_d.wdata = req_wdata;
      hold_d.wmask = req_we ? req_wmask : 4'h0;
      hold_d.seq   = seq_q[LINK_SEQ_W-1:0];
      seq_d        = seq_q + 1'b1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_cpu_fifo_tx.sv
// Randomized scoreboard bench for cpu_fifo_tx: accepted requests queue their
// expected words; a negedge monitor checks every presented and written word.
module tb_cpu_fifo_tx;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic [33:0] fifo_data;
  logic        fifo_w_en, fifo_full, busy;
  logic [15:0] txn_count;

  cpu_fifo_tx #(.WIDTH(34), .SEQ_WIDTH(8)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .fifo_data(fifo_data), .fifo_w_en(fifo_w_en), .fifo_full(fifo_full),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 w_clk = ~w_clk;

  typedef struct { logic [33:0] w; bit last; } exp_t;
  exp_t        q[$];
  int          errors = 0, checks = 0;
  int          exp_cnt = 0;
  int          seq_m = 0;
  int          n_txn = 0;
  bit          mon_on = 0;
  bit          acc = 0;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_mask;

  task automatic chk(input bit ok, input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request becomes its word list straight from the link format.
  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.w = {2'b01, we, (we ? m : 4'h0), 8'(seq_m), 19'h0}; e.last = 0; q.push_back(e);
    e.w = {2'b10, a}; e.last = !we; q.push_back(e);
    if (we) begin e.w = {2'b11, d}; e.last = 1; q.push_back(e); end
    seq_m = (seq_m + 1) % 256;
    n_txn++;
  endtask

  task automatic cycle(input bit v, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit full);
    @(posedge w_clk);
    if (acc) push_txn(s_we, s_addr, s_wdata, s_mask);
    #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_wmask = m; fifo_full = full;
    @(negedge w_clk);
    acc = req_valid && req_ready;
    s_we = req_we; s_addr = req_addr; s_wdata = req_wdata; s_mask = req_wmask;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  // Monitor: every word shown while busy must be the head of the queue.
  initial begin
    forever begin
      @(negedge w_clk);
      if (w_rst || !mon_on) continue;
      chk(txn_count == 16'(exp_cnt), "txn_count", 34'(txn_count), 34'(16'(exp_cnt)));
      if (fifo_w_en && fifo_full) chk(0, "w_en_while_full", 34'(fifo_w_en), 34'h0);
      if (busy) begin
        if (q.size() == 0) chk(0, "busy_no_pending", 34'(busy), 34'h0);
        else begin
          chk(fifo_data == q[0].w, "word", fifo_data, q[0].w);
          if (fifo_w_en) begin
            if (q[0].last) exp_cnt++;
            void'(q.pop_front());
          end
        end
      end else begin
        chk(!fifo_w_en && fifo_data == 34'h0, "idle_outputs", fifo_data, 34'h0);
        if (q.size() != 0) chk(0, "idle_with_pending", 34'(q.size()), 34'h0);
      end
    end
  end

  initial begin
    w_rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; fifo_full = 0;
    repeat (2) @(posedge w_clk);
    #1 w_rst = 0;
    @(negedge w_clk);
    chk(req_ready == 1'b1, "rst_req_ready", 34'(req_ready), 34'h1);
    chk(fifo_w_en == 1'b0, "rst_w_en", 34'(fifo_w_en), 34'h0);
    chk(fifo_data == 34'h0, "rst_data", fifo_data, 34'h0);
    chk(busy == 1'b0, "rst_busy", 34'(busy), 34'h0);
    chk(txn_count == 16'h0, "rst_txn_count", 34'(txn_count), 34'h0);
    mon_on = 1;

    // Directed: read, write, stalled read, four back-to-back reads.
    cycle(1, 0, 32'h0000_1000, 32'h1234_5678, 4'h5, 0);
    idle_cycles(3);
    cycle(1, 1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0);
    idle_cycles(4);
    cycle(1, 0, 32'hCAFE_0000, 32'h0, 4'h0, 0);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 32'h0, 4'h0, 1);
    idle_cycles(3);
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h100 + 32'(i), 32'h0, 4'h0, 0);
    idle_cycles(10);

    // Random phase, long enough to wrap the 8-bit sequence number.
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 8, 1'($urandom), $urandom, $urandom, 4'($urandom),
            $urandom_range(0, 3) == 0);
    idle_cycles(6);
    chk(q.size() == 0, "drain", 34'(q.size()), 34'h0);
    chk(n_txn > 256, "seq_wrapped", 34'(n_txn), 34'd257);

    // Reset while DATA is pending: it must never appear.
    cycle(1, 1, 32'hAAAA_0000, 32'h5555_5555, 4'h3, 0);
    idle_cycles(2);
    @(posedge w_clk);
    #1 fifo_full = 1; w_rst = 1;
    @(posedge w_clk);
    #1 w_rst = 0; fifo_full = 0; q.delete(); exp_cnt = 0; seq_m = 0;
    @(negedge w_clk);
    chk(req_ready == 1'b1, "rst_mid_ready", 34'(req_ready), 34'h1);
    chk(fifo_w_en == 1'b0, "rst_mid_w_en", 34'(fifo_w_en), 34'h0);
    chk(busy == 1'b0, "rst_mid_busy", 34'(busy), 34'h0);
    chk(txn_count == 16'h0, "rst_mid_count", 34'(txn_count), 34'h0);
    idle_cycles(4);
    cycle(1, 0, 32'h0000_0040, 32'h0, 4'h0, 0);
    idle_cycles(5);
    chk(q.size() == 0, "final_drain", 34'(q.size()), 34'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_fifo_tx.md
# cpu_fifo_tx

CPU-side transmitter for the CPU-to-FPGA link. It accepts memory-request transactions from the CPU over a valid/ready handshake and serializes each one into tagged 34-bit words. It pushes those words into the write port of the CPU-to-FPGA asynchronous FIFO, stalling on `full`. It runs entirely in the `w_clk` domain.

## Interface
Parameters:
- `WIDTH`, 34: FIFO word width. Fixed layout `{tag[1:0], payload[31:0]}`; no other value is supported.
- `SEQ_WIDTH`, 8: width of the transaction sequence ID.

Ports:
- `w_clk`, in, 1: write-domain clock.
- `w_rst`, in, 1: reset, synchronous, active-high; clock `w_clk`.
- `req_valid`, in, 1: CPU request valid.
- `req_ready`, out, 1: block can accept a request this cycle.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: write data; ignored for reads.
- `req_wmask`, in, 4: byte enables; ignored for reads.
- `fifo_data`, out, WIDTH: drives FIFO `data_in`.
- `fifo_w_en`, out, 1: drives FIFO `w_en`.
- `fifo_full`, in, 1: FIFO `full`, already synchronized into `w_clk`.
- `busy`, out, 1: a transaction is held and not fully sent.
- `txn_count`, out, 16: count of completed transactions; wraps.

## Operation
- Word tags:
  - 2'b01 HDR. Payload: [31] = we, [30:27] = wmask (0 for reads), [26:19] = seq, [18:0] = 0.
  - 2'b10 ADDR. Payload = addr.
  - 2'b11 DATA. Payload = wdata.
  - 2'b00 is never emitted.
- Word sequences:
  - Read: HDR, ADDR.
  - Write: HDR, ADDR, DATA.
- States:
  - IDLE.
  - S_HDR.
  - S_ADDR.
  - S_DATA.
- Handshake: a request is accepted when `req_valid && req_ready`.
  - On accept, the holding register captures we, addr, wdata, wmask and the current seq.
  - On accept, seq increments (wraps 255 -> 0).
  - Next state is S_HDR.
- Output drive:
  - `fifo_data` is combinational from the state and the holding register.
  - In IDLE, `fifo_data` = 0.
  - `fifo_w_en` = (state != IDLE) && !`fifo_full`.
  - `fifo_w_en` is never high while `fifo_full` is high.
- Advance: state advances only in a cycle where `fifo_w_en` = 1.
  - S_HDR -> S_ADDR.
  - S_ADDR -> S_DATA if we, else last word.
  - S_DATA -> last word.
- Last word is written: `txn_count` increments.
  - If a new request is accepted in the same cycle, next state is S_HDR.
  - Otherwise next state is IDLE.
- `req_ready` = IDLE || (in last-word state && !`fifo_full`).
  - Last-word state is S_ADDR with we = 0, or S_DATA.
  - This allows back-to-back transactions.
- Full: hold state and `fifo_data` stable; retry every cycle until `fifo_full` = 0.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 1.
  - `fifo_w_en` = 0.
  - `fifo_data` = 0.
  - `busy` = 0.
  - `txn_count` = 0.
  - seq = 0.
- Accept cycle N (FIFO not full):
  - HDR is written in cycle N+1.
  - ADDR is written in N+2.
  - DATA is written in N+3 (writes only).
- Throughput with no stall:
  - Reads: 2 cycles per transaction (one word per cycle).
  - Writes: 3 cycles per transaction.
- Each stall cycle on `fifo_full` adds exactly one cycle. No word is dropped or duplicated.
- `req_valid` may drop without acceptance. Request inputs are sampled only in the accept cycle.
- Reset mid-transaction:
  - Return to IDLE on the next edge and discard the held transaction.
  - Partial sequences are the integrator's concern; the FIFO is reset together with this block.
- `txn_count` wraps 0xFFFF -> 0.

## Structure
- Shared package `canary_link_pkg` holds:
  - tag constants (TAG_HDR, TAG_ADDR, TAG_DATA);
  - HDR field bit positions;
  - the `tx_state_t` enum;
  - a packed `link_req_t` struct (we, addr, wdata, wmask, seq).
- Single module; no sub-module is warranted.
- The holding register and the FSM live together in `cpu_fifo_tx`.

## Test plan
- Read addr 0x0000_1000, FIFO never full:
  - Exactly two words are written, 0x1_0000_0000 (HDR, we = 0, seq 0) then 0x2_0000_1000.
  - `txn_count` = 1.
- Write addr 0x8, wdata 0xDEAD_BEEF, wmask 0xF:
  - HDR payload is 0xF800_0000 (we=1, wmask=0xF, seq=0); the ADDR and DATA words follow.
  - Three consecutive `fifo_w_en` cycles.
- `fifo_full` held high for 5 cycles during S_ADDR:
  - `fifo_w_en` stays 0 and `fifo_data` stays stable.
  - ADDR is written on the first not-full cycle.
  - Total latency grows by 5.
- `req_valid` continuously high with 4 reads:
  - 8 words in 8 cycles after the first accept.
  - Seq values 0, 1, 2, 3.
- 256 transactions: the seq field wraps to 0 on the 257th.
- `w_rst` asserted in S_DATA:
  - The next cycle shows IDLE, `req_ready` = 1 and `fifo_w_en` = 0.
  - The remaining DATA word is never emitted.
